// File: rtl/word_align_pkg.sv
// Definitions shared by the word aligner and dealigner: the default word
// width and the three-state handshake FSM encoding.
package word_align_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/word_dealigner.sv
// Restores a left-aligned word by shifting it right one bit per cycle.
// A sticky flag records whether any 1-bit fell off the LSB.
//
// state | meaning
// IDLE  | ready for a new word; outputs hold the last result
// SHIFT | one right shift per cycle until the counter reaches 1
// DONE  | restored word valid, held until out_ready
module word_dealigner
   import word_align_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int SW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_word,
   input  logic [SW-1:0]    in_shift,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_word,
   output logic             out_lost
);

   // Shift counts past WIDTH only exist for non-power-of-2 widths; WIDTH
   // then still fits in SW bits, so the counter can hold the saturated value.
   localparam logic [SW:0] WIDTH_SAT = (SW+1)'(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic [SW-1:0]    cnt_q,   cnt_d;
   logic             lost_q,  lost_d;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      lost_d  = lost_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d = in_word;
               lost_d = 1'b0;
               if ({1'b0, in_shift} >= WIDTH_SAT) begin
                  cnt_d = WIDTH_SAT[SW-1:0];
               end else begin
                  cnt_d = in_shift;
               end
               state_d = (in_shift == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            data_d = {1'b0, data_q[WIDTH-1:1]};
            lost_d = lost_q | data_q[0];
            cnt_d  = cnt_q - SW'(1);
            if (cnt_q == SW'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         lost_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         lost_q  <= lost_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_word  = data_q;
   assign out_lost  = lost_q;

endmodule

// File: tb/tb_word_dealigner.sv
// Self-checking bench for word_dealigner: directed cases plus random
// traffic, with expected results queued at accept and popped at output.
module tb_word_dealigner;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_word;
   logic [2:0] in_shift;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_word;
   logic       out_lost;

   int chk_cnt = 0;
   int err_cnt = 0;
   logic [8:0] sb[$];

   word_dealigner #(.WIDTH(8), .SW(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_word   (in_word),
      .in_shift  (in_shift),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .out_lost  (out_lost)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // {lost, restored word}
   function automatic logic [8:0] model(input logic [7:0] w, input logic [2:0] s);
      logic lost;
      lost = 1'b0;
      for (int i = 0; i < int'(s); i++) lost |= w[i];
      return {lost, w >> s};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_check(input string tag);
      logic [8:0] e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_word"}, {24'd0, out_word}, {24'd0, e[7:0]});
         chk({tag, "_lost"}, {31'd0, out_lost}, {31'd0, e[8]});
      end
   endtask

   task automatic wait_in_ready(input string tag);
      int n;
      n = 0;
      while (!in_ready && n < 64) begin
         step();
         n++;
      end
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic run_one(input logic [7:0] w, input logic [2:0] s, input string tag);
      int lat;
      in_word   = w;
      in_shift  = s;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      wait_in_ready(tag);
      sb.push_back(model(w, s));
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 64) begin
         step();
         lat++;
      end
      chk({tag, "_lat"}, lat, 32'(1 + int'(s)));
      pop_check(tag);
      step();
   endtask

   initial begin
      int n;
      int sent, recv, cyc;
      logic [7:0] cur_w;
      logic [2:0] cur_s;
      logic [8:0] e;

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_word   = 8'h00;
      in_shift  = 3'd0;
      out_ready = 1'b0;
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_word", {24'd0, out_word}, 32'd0);
      chk("rst_out_lost", {31'd0, out_lost}, 32'd0);
      #11;
      reset = 1'b0;
      #4;

      run_one(8'hA0, 3'd3, "a0_s3");
      chk("idle_hold_word", {24'd0, out_word}, 32'h14);
      run_one(8'h81, 3'd2, "81_s2");
      run_one(8'hC3, 3'd0, "c3_s0");
      run_one(8'h80, 3'd7, "80_s7");
      run_one(8'h00, 3'd5, "zero_s5");

      // Backpressure: hold the result while new data waits
      in_word   = 8'hA5;
      in_shift  = 3'd2;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      wait_in_ready("bp");
      sb.push_back(model(8'hA5, 3'd2));
      step();
      in_word  = 8'h3C;
      in_shift = 3'd1;
      n = 0;
      while (!out_valid && n < 64) begin
         step();
         n++;
      end
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_hold_word", {24'd0, out_word}, 32'h29);
         chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      pop_check("bp");
      step();
      chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
      chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
      sb.push_back(model(8'h3C, 3'd1));
      step();
      in_valid = 1'b0;
      chk("bp_next_busy", {31'd0, in_ready}, 32'd0);
      n = 0;
      while (!out_valid && n < 64) begin
         step();
         n++;
      end
      pop_check("bp_next");
      step();

      // Asynchronous reset during the second SHIFT cycle
      in_word   = 8'hFF;
      in_shift  = 3'd5;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      wait_in_ready("rst_mid");
      sb.push_back(model(8'hFF, 3'd5));
      step();
      step();
      #2;
      reset = 1'b1;
      #1;
      chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_word", {24'd0, out_word}, 32'd0);
      chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
      sb.delete();
      step();
      chk("rst_hold_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_hold_word", {24'd0, out_word}, 32'd0);
      in_valid = 1'b0;
      #2;
      reset = 1'b0;
      #2;
      run_one(8'hF0, 3'd4, "rst_fresh");

      // Random traffic with stalls on both sides
      sent  = 0;
      recv  = 0;
      cyc   = 0;
      cur_w = 8'($urandom);
      cur_s = 3'($urandom_range(0, 7));
      while (recv < 100 && cyc < 20000) begin
         in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
         in_word   = cur_w;
         in_shift  = cur_s;
         out_ready = ($urandom_range(0, 3) != 0);
         if (in_valid && in_ready) begin
            sb.push_back(model(cur_w, cur_s));
            sent++;
            cur_w = 8'($urandom);
            cur_s = 3'($urandom_range(0, 7));
         end
         if (out_valid && out_ready) begin
            pop_check("rnd");
            recv++;
         end
         step();
         cyc++;
      end
      in_valid = 1'b0;
      chk("rnd_count", recv, 32'd100);
      chk("rnd_sb_left", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/word_dealigner.md
WORD_DEALIGNER -- requirements
Module: word_dealigner

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the data word width in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter SW, default $clog2(WIDTH), the shift-count width in bits.
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  upstream presents a word and shift count.
REQ-006 The block SHALL have port in_ready  output  1  block can accept a word.
REQ-007 The block SHALL have port in_word  input  WIDTH  left-aligned (MSB-normalized) word.
REQ-008 The block SHALL have port in_shift  input  SW  number of right shifts needed to restore the original word.
REQ-009 The block SHALL have port out_valid  output  1  restored word available.
REQ-010 The block SHALL have port out_ready  input  1  downstream accepts the restored word.
REQ-011 The block SHALL have port out_word  output  WIDTH  restored (right-shifted, zero-filled) word.
REQ-012 The block SHALL have port out_lost  output  1  sticky flag: at least one 1-bit was shifted out of the LSB.

Function
REQ-013 The block SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL be a decode of state == IDLE, with no bypass from DONE.
REQ-015 Accept SHALL occur on a clock edge with in_valid && in_ready; the block SHALL register in_word into the data register, in_shift into the down-counter, clear out_lost, and ignore in_valid in all other states.
REQ-016 On accept with in_shift == 0, next state SHALL be DONE; otherwise next state SHALL be SHIFT.
REQ-017 Each SHIFT cycle SHALL perform a logical right shift by exactly 1 with zero fill at the MSB.
REQ-018 Each SHIFT cycle SHALL OR the departing LSB into out_lost and decrement the counter.
REQ-019 When the counter reaches 1 during a SHIFT cycle, that cycle SHALL perform its final shift and the next state SHALL be DONE.
REQ-020 Latency SHALL be exactly 1 + in_shift cycles from the accept edge to out_valid high.
REQ-021 out_valid SHALL be high only in DONE.
REQ-022 out_word and out_lost SHALL be held stable while out_valid is high and out_ready is low, with no timeout.
REQ-023 DONE with out_ready high at the clock edge SHALL complete the output handshake; next state SHALL be IDLE, and the earliest next accept SHALL be on the following edge.
REQ-024 out_word SHALL equal in_word >> in_shift, truncated to WIDTH bits, with no arithmetic (sign) extension.
REQ-025 in_shift values >= WIDTH, possible only when WIDTH is not a power of 2, SHALL saturate to WIDTH, giving out_word = 0 and out_lost = |in_word.
REQ-026 in_word = 0 SHALL be handled like any other word: out_word = 0, out_lost = 0, full latency applies.
REQ-027 out_word and out_lost SHALL retain their last values in IDLE; they are qualified only by out_valid.

Reset
REQ-028 Asserting reset SHALL immediately, without waiting for clk, force state = IDLE, data register = 0, counter = 0 and out_lost = 0.
REQ-029 While reset is asserted, out_valid SHALL read 0, out_word SHALL read 0 and in_ready SHALL read 1, with no accept occurring.
REQ-030 Reset asserted mid-SHIFT or in DONE SHALL abandon the in-flight word with no output handshake.
REQ-031 The first accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-032 A shared package word_align_pkg SHALL hold the FSM state type (IDLE/SHIFT/DONE) and the WIDTH default constant, so the aligner and dealigner use the same word-width definitions.
REQ-033 The block SHALL be a single module with no sub-module; the shift register, counter and FSM are small enough to keep inline.

Verification
REQ-034 The bench SHALL drive in_word=8'hA0, in_shift=3, with out_ready high, and check out_word=8'h14, out_lost=0, and out_valid high exactly 4 cycles after the accept edge.
REQ-035 The bench SHALL drive in_word=8'h81, in_shift=2, and check out_word=8'h20 and out_lost=1.
REQ-036 The bench SHALL drive in_word=8'hC3, in_shift=0, and check out_word=8'hC3 with out_valid high 1 cycle after accept; then drive in_word=8'h80, in_shift=7, and check out_word=8'h01 after 8 cycles.
REQ-037 The bench SHALL hold out_ready low for 5 cycles in DONE while driving in_valid high with new data, and check that out_valid stays high, out_word is unchanged, in_ready stays 0, and the new data is not accepted until the cycle after out_ready is raised and the block returns to IDLE.
REQ-038 The bench SHALL assert reset asynchronously (mid-cycle) during the second cycle of SHIFT with in_shift=5, and check that out_valid=0, out_word=0 and in_ready=1 before the next clk edge, and that a fresh in_word=8'hF0, in_shift=4 then yields 8'h0F.
REQ-039 The bench SHALL run back-to-back traffic of 100 random {in_word, in_shift} pairs with random in_valid/out_ready stalls, and check every output against a scoreboard computing in_word >> in_shift and the OR of the dropped bits.
